// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster scan source for the pixel-coordinate interface. A horizontal and a
//   vertical position counter advance one pixel on each clk edge where
//   pix_ce_in is high. Every output is registered and decoded from the
//   next-state counter values, so all outputs describe the same (h, v)
//   position with no relative skew.
//
// Ports
//   clk              system clock, rising edge
//   rst              asynchronous, active-high reset
//   pix_ce_in        pixel enable; one scan position per enabled edge
//   pix_x_out[10:0]  horizontal position h_cnt, 0..H_TOTAL-1
//   pix_y_out[9:0]   vertical position v_cnt, 0..V_TOTAL-1
//   in_screen_out    high while inside the visible area
//   hsync_out        horizontal sync, level H_POL inside the pulse
//   vsync_out        vertical sync, level V_POL inside the pulse
//   line_start_out   one-clk pulse on arriving at h_cnt = 0
//   frame_start_out  one-clk pulse on arriving at (0, 0)
module vga_timing_gen #(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 64,
  parameter int   H_SYNC   = 136,
  parameter int   H_BP     = 200,
  parameter int   V_ACTIVE = 800,
  parameter int   V_FP     = 1,
  parameter int   V_SYNC   = 3,
  parameter int   V_BP     = 24,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce_in,
  output logic [10:0] pix_x_out,
  output logic [9:0]  pix_y_out,
  output logic        in_screen_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        line_start_out,
  output logic        frame_start_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2048 || V_TOTAL > 1024 ||
      H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_params
    $error("vga_timing_gen: timing parameters out of range");
  end

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
  localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_cnt, h_nxt;
  logic [9:0]  v_cnt, v_nxt;

  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (pix_ce_in) begin
      if (h_cnt == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_nxt = h_cnt + 11'd1;
      end
    end
  end

  // Reset parks the scan on the last blanking position so the first enabled
  // edge lands on (0, 0) and the first frame is complete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt           <= H_LAST;
      v_cnt           <= V_LAST;
      in_screen_out   <= 1'b0;
      hsync_out       <= ~H_POL;
      vsync_out       <= ~V_POL;
      line_start_out  <= 1'b0;
      frame_start_out <= 1'b0;
    end else begin
      h_cnt           <= h_nxt;
      v_cnt           <= v_nxt;
      in_screen_out   <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
      hsync_out       <= (h_nxt >= HS_START && h_nxt < HS_END) ? H_POL : ~H_POL;
      vsync_out       <= (v_nxt >= VS_START && v_nxt < VS_END) ? V_POL : ~V_POL;
      // Pulses need an actual advance; a stall parked at 0 must not re-fire.
      line_start_out  <= pix_ce_in && (h_nxt == '0);
      frame_start_out <= pix_ce_in && (h_nxt == '0) && (v_nxt == '0);
    end
  end

  assign pix_x_out = h_cnt;
  assign pix_y_out = v_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: three instances (default 1280x800 timing,
// 640x480 timing, and a tiny raster so whole frames wrap quickly) share clk,
// rst and pix_ce_in. A reference model tracks each scan as a linear pixel
// index modulo the frame size and derives coordinates and decodes with
// division/modulo arithmetic.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ce  = 1'b0;

  always #5 clk = ~clk;

  logic [10:0] d_x, v_x, s_x;
  logic [9:0]  d_y, v_y, s_y;
  logic d_ins, d_hs, d_vs, d_ls, d_fs;
  logic v_ins, v_hs, v_vs, v_ls, v_fs;
  logic s_ins, s_hs, s_vs, s_ls, s_fs;

  vga_timing_gen u_def (
    .clk(clk), .rst(rst), .pix_ce_in(ce),
    .pix_x_out(d_x), .pix_y_out(d_y), .in_screen_out(d_ins),
    .hsync_out(d_hs), .vsync_out(d_vs),
    .line_start_out(d_ls), .frame_start_out(d_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
    .H_POL(1'b0), .V_POL(1'b0)
  ) u_vga (
    .clk(clk), .rst(rst), .pix_ce_in(ce),
    .pix_x_out(v_x), .pix_y_out(v_y), .in_screen_out(v_ins),
    .hsync_out(v_hs), .vsync_out(v_vs),
    .line_start_out(v_ls), .frame_start_out(v_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b0)
  ) u_sml (
    .clk(clk), .rst(rst), .pix_ce_in(ce),
    .pix_x_out(s_x), .pix_y_out(s_y), .in_screen_out(s_ins),
    .hsync_out(s_hs), .vsync_out(s_vs),
    .line_start_out(s_ls), .frame_start_out(s_fs)
  );

  localparam longint TOT_D = 1680 * 828;
  localparam longint TOT_V = 800 * 525;
  localparam longint TOT_S = 15 * 9;

  int total = 0;
  int bad   = 0;
  longint pos_d, pos_v, pos_s;
  bit adv;
  int cyc = 0;
  int last_ls = -1, prev_ls = -1;
  int hs_low;

  // Expected {x, y, in_screen, hsync, vsync, line_start, frame_start}
  function automatic logic [25:0] model(int ha, int hf, int hs, int hb,
                                        int va, int vf, int vs, int vb,
                                        bit hp, bit vp, longint pos, bit a);
    int ht = ha + hf + hs + hb;
    int vt = va + vf + vs + vb;
    int h  = int'(pos % ht);
    int v  = int'((pos / ht) % vt);
    logic ins = (h < ha) && (v < va);
    logic hsy = (h >= ha + hf && h < ha + hf + hs) ? hp : ~hp;
    logic vsy = (v >= va + vf && v < va + vf + vs) ? vp : ~vp;
    return {11'(h), 10'(v), ins, hsy, vsy, a && (h == 0), a && (h == 0) && (v == 0)};
  endfunction

  task automatic chk(input string tag, input longint act, input longint exp);
    total++;
    assert (act === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/def"}, {d_x, d_y, d_ins, d_hs, d_vs, d_ls, d_fs},
        model(1280, 64, 136, 200, 800, 1, 3, 24, 1'b0, 1'b1, pos_d, adv));
    chk({tag, "/vga"}, {v_x, v_y, v_ins, v_hs, v_vs, v_ls, v_fs},
        model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, pos_v, adv));
    chk({tag, "/sml"}, {s_x, s_y, s_ins, s_hs, s_vs, s_ls, s_fs},
        model(8, 2, 3, 2, 5, 1, 2, 1, 1'b1, 1'b0, pos_s, adv));
  endtask

  task automatic park_model();
    pos_d = TOT_D - 1;
    pos_v = TOT_V - 1;
    pos_s = TOT_S - 1;
    adv   = 1'b0;
  endtask

  task automatic step(input bit c, input string tag);
    ce = c;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      park_model();
    end else if (c) begin
      pos_d = (pos_d + 1) % TOT_D;
      pos_v = (pos_v + 1) % TOT_V;
      pos_s = (pos_s + 1) % TOT_S;
      adv   = 1'b1;
    end else begin
      adv = 1'b0;
    end
    if (d_ls) begin
      prev_ls = last_ls;
      last_ls = cyc;
    end
    check_all(tag);
  endtask

  initial begin
    park_model();
    // Asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #2;
    chk("rst_x",   d_x, 1679);
    chk("rst_y",   d_y, 827);
    chk("rst_ins", d_ins, 0);
    chk("rst_hs",  d_hs, 1);
    chk("rst_vs",  d_vs, 0);
    chk("rst_ls",  d_ls, 0);
    chk("rst_fs",  d_fs, 0);
    chk("rst_vga_x", v_x, 799);
    chk("rst_vga_y", v_y, 524);
    check_all("rst_async");

    // Enable during reset is ignored
    step(1'b1, "rst_ce");
    step(1'b1, "rst_ce");
    rst = 1'b0;

    step(1'b1, "first");
    chk("first_x",  d_x, 0);
    chk("first_y",  d_y, 0);
    chk("first_ins", d_ins, 1);
    chk("first_ls", d_ls, 1);
    chk("first_fs", d_fs, 1);

    // Rest of line 0 with enable tied high
    hs_low = 0;
    for (int i = 1; i <= 1679; i++) begin
      step(1'b1, "line0");
      if (d_hs == 1'b0) hs_low++;
      if (i == 1279) chk("ins_1279", d_ins, 1);
      if (i == 1280) chk("ins_1280", d_ins, 0);
      if (i == 1344) chk("hs_1344", d_hs, 0);
      if (i == 1479) chk("hs_1479", d_hs, 0);
      if (i == 1480) chk("hs_1480", d_hs, 1);
    end
    chk("hsync_width", hs_low, 136);
    chk("end_x", d_x, 1679);

    // Stall pattern 1,0,0,1 across the line wrap
    step(1'b1, "wrap");
    chk("wrap_x", d_x, 0);
    chk("wrap_y", d_y, 1);
    chk("wrap_ls", d_ls, 1);
    chk("wrap_fs", d_fs, 0);
    chk("line_period", last_ls - prev_ls, 1680);
    step(1'b0, "stall1");
    chk("stall1_x", d_x, 0);
    chk("stall1_ls", d_ls, 0);
    step(1'b0, "stall2");
    chk("stall2_ls", d_ls, 0);
    step(1'b1, "resume");
    chk("resume_x", d_x, 1);
    chk("resume_ls", d_ls, 0);

    // Random pixel enable; small raster wraps many frames
    for (int i = 0; i < 20000; i++)
      step($urandom_range(3) != 0, "rand");

    // Mid-frame reset, no clock edge needed
    rst = 1'b1;
    #2;
    park_model();
    check_all("rst_mid");
    chk("rst_mid_x", d_x, 1679);
    step(1'b1, "rst_mid_ce");
    rst = 1'b0;
    step(1'b1, "after_rst");
    chk("after_rst_fs", d_fs, 1);
    chk("after_rst_x", d_x, 0);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(1) != 0, "rand2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
